// File: rtl/reg_file_rd.sv
// reg_file_rd: 8x8 register file with a one-entry pending write stage and two combinational read ports
// Define REG_BYPASS_EN to let reads see the value still held in the pending stage.
module reg_file_rd #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [2:0]       wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             flush,
    input  logic [2:0]       rd_a_addr,
    input  logic [2:0]       rd_b_addr,
    output logic [WIDTH-1:0] rd_a_data,
    output logic [WIDTH-1:0] rd_b_data,
    output logic             pend_valid,
    output logic [2:0]       pend_addr
);
    typedef enum logic {IDLE, PENDING} state_t;
    state_t           state;
    logic [WIDTH-1:0] pend_data;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             load;
    assign load       = wr_en & ~flush;
    assign pend_valid = (state == PENDING);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            state     <= IDLE;
            pend_addr <= '0;
            pend_data <= '0;
        end else begin
            if (state == PENDING && !flush) mem[pend_addr] <= pend_data;
            state     <= load ? PENDING : IDLE;
            pend_addr <= load ? wr_addr : '0;
            pend_data <= load ? wr_data : '0;
        end
    end
`ifdef REG_BYPASS_EN
    // flush only acts at the edge, so the pending value is still shown during a flush cycle
    always_comb begin
        rd_a_data = (pend_valid && rd_a_addr == pend_addr) ? pend_data : mem[rd_a_addr];
        rd_b_data = (pend_valid && rd_b_addr == pend_addr) ? pend_data : mem[rd_b_addr];
    end
`else
    always_comb begin
        rd_a_data = mem[rd_a_addr];
        rd_b_data = mem[rd_b_addr];
    end
`endif
endmodule
